dat_fifo: RTL and testbench
===========================

// Module: dat_fifo
// PURPOSE
//  Synchronous 32-bit data buffer between the host-side data bus and the DAT physical stage.
//  Direction is set by writeRead:
//   - Card write (writeRead=1): the host fills the buffer and the DAT phys stage drains it.
//   - Card read (writeRead=0): the DAT phys stage fills it and the host drains it.
//  Show-ahead read data feeds the phys frame builder directly; status tells the phys controller whether it may proceed.
// PARAMETERS
//  DATA_WIDTH  32  word width, equal to one DAT frame payload
//  ADDR_WIDTH  3   pointer width; depth = 2**ADDR_WIDTH = 8 words
// PORTS
//  sd_clock            in   1           single clock; all state changes on rising edge
//  reset               in   1           synchronous, active-low
//  writeRead           in   1           1=card write (host->FIFO->phys), 0=card read (phys->FIFO->host)
//  flush               in   1           sync clear of pointers, level and error flags
//  host_write_enable   in   1           host push (honoured only when writeRead=1)
//  host_data_in        in   DATA_WIDTH  host push data
//  host_read_enable    in   1           host pop (honoured only when writeRead=0)
//  host_data_out       out  DATA_WIDTH  show-ahead head word for the host
//  write_enable        in   1           phys push (honoured only when writeRead=0)
//  dataToFIFO          in   DATA_WIDTH  phys push data
//  read_enable         in   1           phys pop (honoured only when writeRead=1)
//  dataFROMFIFO        out  DATA_WIDTH  show-ahead head word for the phys frame builder
//  status              out  1           writeRead=1: !empty (word available); writeRead=0: !full (space available)
//  empty               out  1           level==0
//  full                out  1           level==2**ADDR_WIDTH
//  level               out  ADDR_WIDTH+1  words stored
//  overflow            out  1           sticky: push rejected while full
//  underflow           out  1           sticky: pop rejected while empty
// BEHAVIOUR
//  - Reset (reset=0 at edge):
//    - wr_ptr=rd_ptr=0, level=0, overflow=underflow=0.
//    - Outputs: empty=1, full=0, status=writeRead ? 0 : 1.
//    - Memory contents are not cleared.
//  - Port selection is combinational from writeRead:
//    - push = writeRead ? host_write_enable : write_enable
//    - pop  = writeRead ? read_enable : host_read_enable
//    - Enables on the unselected side are ignored and set no flags.
//  - Read data is show-ahead: host_data_out = dataFROMFIFO = mem[rd_ptr]. It is valid whenever empty=0 and undefined when empty=1.
//  - Pop accepted iff !empty. On an accepted pop, rd_ptr+1 and the next word appears the following cycle.
//  - Push accepted iff !full, or full with an accepted pop in the same cycle. On an accepted push, the data is written to mem[wr_ptr] and wr_ptr+1.
//  - Pointers wrap modulo 2**ADDR_WIDTH; level is tracked by a separate ADDR_WIDTH+1 counter.
//  - Level update per cycle: +1 push only; -1 pop only; unchanged for both or neither.
//  - Simultaneous push+pop on empty: the pop is rejected (underflow=1) and the push is accepted, so level becomes 1.
//  - Rejected push: memory and pointers are unchanged and overflow is set.
//  - Rejected pop: pointers are unchanged and underflow is set.
//  - Both flags stay set until flush or reset.
//  - flush=1 has the same effect as reset on pointers, level and flags. flush has priority over any push/pop in the same cycle.
//  - A writeRead change does not clear contents. Upstream issues flush before each transfer; a mid-transfer toggle only re-routes ports.
//  - status, empty, full and level reflect registered state. There is no combinational path from the enables to these flags.
//  - Latency: a word pushed at edge N is visible on the read outputs after edge N (zero-cycle bubble beyond the register).
// STRUCTURE
//  - dat_pkg holds:
//    - DAT_DATA_WIDTH=32
//    - DAT_FIFO_ADDR_WIDTH=3
//    - the DAT_FRAME_SIZE=50 constant shared with the DAT phys stage
//  - One sub-module, dat_fifo_mem:
//    - 2**ADDR_WIDTH x DATA_WIDTH register file
//    - one synchronous write port, one asynchronous read port
//  - Pointers, level, flags and the writeRead port mux stay in dat_fifo.
// TESTING
//  1. Reset: hold reset=0 for 2 cycles, writeRead=1.
//     -> empty=1, full=0, level=0, status=0, overflow=underflow=0.
//  2. Card write: push 8 host words 0xA0000000..0xA0000007.
//     -> full=1, status=1, level=8.
//     Then 8 read_enable pops.
//     -> dataFROMFIFO shows the words in order; empty=1 and status=0 after the last pop.
//  3. Overflow/underflow: on a full FIFO, a 9th host push alone -> overflow=1, level stays 8, contents intact.
//     Draining to empty, then one extra pop -> underflow=1.
//     flush -> both flags clear.
//  4. Simultaneous: at level=8, push+pop in one cycle -> both accepted, level=8, wr_ptr wraps to 1.
//     At level=0, push+pop -> level=1, underflow=1.
//  5. Card read: writeRead=0, phys pushes 3 words via write_enable/dataToFIFO.
//     -> host_data_out shows word0, status=1.
//     Host pops 3 -> empty=1.
//     read_enable pulses during this phase -> no pointer change and no flags.
//  6. Reset mid-transfer: at level=5, assert reset=0 together with push+pop.
//     -> next cycle level=0, empty=1, no flags.
//     Subsequent single push -> level=1.

Source files
------------

// File: rtl/dat_pkg.sv
// Shared constants for the DAT data path: word width, buffer depth and the
// frame size agreed with the DAT physical stage.
package dat_pkg;

  localparam int DAT_DATA_WIDTH      = 32;
  localparam int DAT_FIFO_ADDR_WIDTH = 3;
  localparam int DAT_FRAME_SIZE      = 50;

  typedef logic [DAT_DATA_WIDTH-1:0] dat_word_t;

endpackage

// File: rtl/dat_fifo_mem.sv
// Register-file storage for dat_fifo: one synchronous write port and one
// asynchronous read port so the head word is visible without a read cycle.
module dat_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the level counter, and
  // leaving it out lets the array map onto plain register-file cells.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dat_fifo.sv
// Direction-switched show-ahead FIFO between the host data bus and the DAT
// phys stage; writeRead selects which side pushes and which side pops.
module dat_fifo
  import dat_pkg::*;
#(
  parameter int DATA_WIDTH = DAT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DAT_FIFO_ADDR_WIDTH
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  writeRead,
  input  logic                  flush,
  input  logic                  host_write_enable,
  input  logic [DATA_WIDTH-1:0] host_data_in,
  input  logic                  host_read_enable,
  output logic [DATA_WIDTH-1:0] host_data_out,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] dataToFIFO,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] dataFROMFIFO,
  output logic                  status,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  push_req, pop_req, push_ok, pop_ok, mem_we;
  logic [DATA_WIDTH-1:0] push_data, head_word;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LEVEL_FULL);
  assign status    = writeRead ? !empty : !full;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign push_req  = writeRead ? host_write_enable : write_enable;
  assign pop_req   = writeRead ? read_enable : host_read_enable;
  assign push_data = writeRead ? host_data_in : dataToFIFO;

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && (!full || pop_ok);
  assign mem_we  = push_ok && !flush && reset;

  // NOTE: combinational next-state uses blocking assignments, with every
  // target defaulted first so no latch can be inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (push_req && !push_ok) overflow_d  = 1'b1;
      if (pop_req && !pop_ok)   underflow_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  dat_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (sd_clock),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(push_data),
    .raddr(rd_ptr_q),
    .rdata(head_word)
  );

  assign host_data_out = head_word;
  assign dataFROMFIFO  = head_word;

endmodule

// File: tb/tb_dat_fifo.sv
// Self-checking bench for dat_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_dat_fifo;
  import dat_pkg::*;

  localparam int DW    = DAT_DATA_WIDTH;
  localparam int AW    = DAT_FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          sd_clock = 1'b0;
  logic          reset, writeRead, flush;
  logic          host_write_enable, host_read_enable, write_enable, read_enable;
  dat_word_t     host_data_in, dataToFIFO, host_data_out, dataFROMFIFO;
  logic          status, empty, full, overflow, underflow;
  logic [AW:0]   level;

  int errors = 0;
  int checks = 0;

  dat_word_t model_q[$];
  bit        m_ovf, m_udf;

  dat_fifo dut (
    .sd_clock         (sd_clock),
    .reset            (reset),
    .writeRead        (writeRead),
    .flush            (flush),
    .host_write_enable(host_write_enable),
    .host_data_in     (host_data_in),
    .host_read_enable (host_read_enable),
    .host_data_out    (host_data_out),
    .write_enable     (write_enable),
    .dataToFIFO       (dataToFIFO),
    .read_enable      (read_enable),
    .dataFROMFIFO     (dataFROMFIFO),
    .status           (status),
    .empty            (empty),
    .full             (full),
    .level            (level),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded queue with pop-before-push ordering.
  task automatic model_update();
    bit push_req, pop_req, pop_ok, push_ok;
    if (!reset || flush) begin
      model_q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      push_req = writeRead ? host_write_enable : write_enable;
      pop_req  = writeRead ? read_enable : host_read_enable;
      pop_ok   = pop_req && (model_q.size() > 0);
      push_ok  = push_req && ((model_q.size() < DEPTH) || pop_ok);
      if (pop_req && !pop_ok)   m_udf = 1;
      if (push_req && !push_ok) m_ovf = 1;
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(writeRead ? host_data_in : dataToFIFO);
    end
  endtask

  task automatic check_all();
    bit e_empty, e_full;
    e_empty = (model_q.size() == 0);
    e_full  = (model_q.size() == DEPTH);
    check("level", level, model_q.size());
    check("empty", empty, e_empty);
    check("full", full, e_full);
    check("status", status, writeRead ? !e_empty : !e_full);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    if (!e_empty) begin
      check("host_data_out", host_data_out, model_q[0]);
      check("dataFROMFIFO", dataFROMFIFO, model_q[0]);
    end
  endtask

  task automatic tick();
    @(posedge sd_clock);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle();
    host_write_enable = 0;
    host_read_enable  = 0;
    write_enable      = 0;
    read_enable       = 0;
    flush             = 0;
  endtask

  task automatic host_fill(input dat_word_t base, input int n);
    for (int i = 0; i < n; i++) begin
      host_write_enable = 1;
      host_data_in      = base + dat_word_t'(i);
      tick();
    end
    host_write_enable = 0;
  endtask

  task automatic phys_drain(input int n);
    read_enable = 1;
    for (int i = 0; i < n; i++) tick();
    read_enable = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  initial begin
    idle();
    host_data_in = '0;
    dataToFIFO   = '0;
    writeRead    = 1;

    // 1. reset held two cycles
    reset = 0;
    tick();
    tick();
    reset = 1;
    check("reset_level", level, 0);
    check("reset_status", status, 0);

    // 2. card write: fill then drain in order
    host_fill(32'hA000_0000, 8);
    check("fill_full", full, 1);
    check("fill_level", level, 8);
    phys_drain(8);
    check("drain_empty", empty, 1);

    // 3. overflow on full, underflow on empty, flush clears both
    host_fill(32'hA100_0000, 8);
    host_write_enable = 1;
    host_data_in      = 32'hDEAD_BEEF;
    tick();
    host_write_enable = 0;
    check("ovf_set", overflow, 1);
    phys_drain(8);
    phys_drain(1);
    check("udf_set", underflow, 1);
    do_flush();
    check("flush_ovf", overflow, 0);
    check("flush_udf", underflow, 0);

    // 4. simultaneous push+pop at full, then at empty
    host_fill(32'hB000_0000, 8);
    host_write_enable = 1;
    host_data_in      = 32'hC000_0000;
    read_enable       = 1;
    tick();
    idle();
    check("sim_full_level", level, 8);
    phys_drain(8);
    host_write_enable = 1;
    host_data_in      = 32'hC100_0000;
    read_enable       = 1;
    tick();
    idle();
    check("sim_empty_level", level, 1);
    check("sim_empty_udf", underflow, 1);
    do_flush();

    // 5. card read: phys pushes, host pops, stray read_enable ignored
    writeRead = 0;
    do_flush();
    for (int i = 0; i < 3; i++) begin
      write_enable = 1;
      dataToFIFO   = 32'hD000_0000 + dat_word_t'(i);
      tick();
    end
    write_enable = 0;
    check("rd_head", host_data_out, 32'hD000_0000);
    read_enable = 1;
    tick();
    read_enable = 0;
    for (int i = 0; i < 3; i++) begin
      host_read_enable = 1;
      read_enable      = (i == 1);
      tick();
    end
    idle();
    check("rd_empty", empty, 1);
    check("rd_no_udf", underflow, 0);

    // 6. reset mid-transfer with push+pop
    writeRead = 1;
    do_flush();
    host_fill(32'hE000_0000, 5);
    reset             = 0;
    host_write_enable = 1;
    read_enable       = 1;
    tick();
    idle();
    reset = 1;
    check("midreset_level", level, 0);
    host_fill(32'hE100_0000, 1);
    check("post_reset_level", level, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) writeRead = 1'($urandom_range(0, 1));
      flush             = ($urandom_range(0, 63) == 0);
      reset             = !($urandom_range(0, 127) == 0);
      host_write_enable = 1'($urandom);
      host_read_enable  = 1'($urandom);
      write_enable      = 1'($urandom);
      read_enable       = 1'($urandom);
      host_data_in      = $urandom;
      dataToFIFO        = $urandom;
      tick();
    end
    idle();
    reset = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
